decode_queue: RTL and testbench
===============================

# decode_queue

Registered, buffered RV32I instruction decoder with an optional RV32M extension, sitting between instruction fetch and execute. Fetched instruction/PC pairs enter a parametrised FIFO through a valid/ready handshake. The head entry is decoded and captured in an output register that drives execute through a second valid/ready handshake. The block adds back-pressure, flush, illegal-instruction detection and M-extension decode.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2.
- EN_M, 0: 1 enables RV32M decode; 0 flags opcode 0110011 with funct7=0000001 as illegal.
- PC_W, 32: PC width.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous; drops all queued and registered instructions.
- in_valid / in_ready  in / out  1 / 1  fetch-side handshake.
- in_instr  in  32  raw instruction.
- in_pc  in  PC_W  instruction address.
- out_valid / out_ready  out / in  1 / 1  execute-side handshake.
- out_pc  out  PC_W  PC of the decoded instruction.
- out_imm  out  32  immediate: LUI/AUIPC/JAL/JALR/B/load/store/I-ALU formats; shamt zero-extended.
- out_rs1, out_rs2, out_rd  out  5 each  instr[19:15], [24:20], [11:7].
- out_reg_write  out  1  register writeback enable.
- out_alu_src  out  1  0 = rs2, 1 = immediate.
- out_alu_ctrl  out  4  ADD 0000, SUB 0001, AND 0011, OR 0100, XOR 0101, SLT 0110, SLTU 0111, SLL 1000, SRL 1001, SRA 1010, EQ 1011.
- out_wb_src  out  1  1 = immediate writeback (LUI).
- out_alu_r1  out  1  1 = PC as operand A (AUIPC).
- out_is_jal, out_is_jalr, out_is_b  out  1 each  control-flow flags.
- out_b_type  out  3  BEQ 001, BNE 010, BLT 011, BGE 100, BLTU 101, BGEU 110, else 000.
- out_is_load, out_is_store  out  3 each  funct3 for load/store, else 111.
- out_is_md  out  1  M-extension operation; funct3 carried in out_md_op.
- out_md_op  out  3  MUL..REMU select.
- out_illegal  out  1  undecodable instruction.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- Push: in_valid && in_ready. in_ready = !full; no push-into-full even if a pop occurs the same cycle.
- Pop: the FIFO is non-empty and the output register is free (!out_valid || out_ready). The head is decoded combinationally, and the decoded bundle plus PC load into the output register; out_valid is set.
- The output register holds stable while out_valid && !out_ready.
- Write and read pointers wrap modulo DEPTH. count is updated +1 on push, -1 on pop, unchanged on both or neither.
- Decode rules:
  - reg_write for LUI, AUIPC, OP-IMM, OP, JAL, JALR, LOAD, and M ops when EN_M=1.
  - alu_src for OP-IMM, JAL, JALR, AUIPC, LOAD, STORE.
  - Branch alu_ctrl: EQ for BEQ/BNE, SLT for BLT/BGE, SLTU for BLTU/BGEU.
  - LOAD/STORE use ADD.
- Illegal cases:
  - unknown opcode;
  - OP with an unsupported funct7/funct3 pair;
  - SLLI/SRLI/SRAI with a bad funct7;
  - branch funct3 010/011;
  - any M op when EN_M=0.
- On illegal: out_illegal=1, reg_write=0, all flags 0, is_load/is_store=111, imm=0. The entry is still delivered so execute can trap.
- Flush: at the edge where flush=1, the FIFO empties (pointers and count 0) and out_valid clears. A push offered in the same cycle is discarded. Flush has priority over push and pop.

## Timing
- Reset (rst_n low, asynchronous): pointers 0, count 0, out_valid 0, in_ready 1, all decoded outputs 0 except out_is_load=out_is_store=111. Reset mid-operation discards all contents.
- Latency: push at edge k into an empty block gives out_valid=1 after edge k+1, which is 2 edges from fetch handshake to execute visibility.
- Throughput: one instruction per cycle while out_ready=1 continuously.
- in_ready depends only on count, never combinationally on out_ready.
- Back-pressure: out_ready=0 lets the FIFO fill. With DEPTH entries in the FIFO plus 1 in the output register, in_ready=0 until a pop frees a slot.

## Test plan
- Reset then push ADDI x1,x0,-5 (0xFFB00093) with out_ready=1 → out_valid after 2 edges; imm=0xFFFFFFFB, rd=1, alu_ctrl=0000, alu_src=1, reg_write=1, illegal=0.
- Stream 8 instructions with DEPTH=4 and out_ready=0 → in_ready drops after 5 accepts (4 queued + 1 registered), count=4. Release out_ready → program order preserved across pointer wrap, no loss or duplication.
- EN_M=0, MUL x3,x1,x2 (0x022081B3) → illegal=1, reg_write=0. EN_M=1 → is_md=1, md_op=000, reg_write=1.
- BGEU (funct3 111) → is_b=1, b_type=110, alu_ctrl=0111. Opcode 0x7F → illegal=1, is_load=is_store=111.
- With 3 entries queued and out_valid=1, assert flush together with in_valid → next cycle count=0, out_valid=0, the concurrent input is dropped.
- Assert rst_n low mid-stream between clock edges → outputs reach reset values immediately, without waiting for an edge.

Source files
------------

// File: rtl/decode_queue.sv
// Buffered RV32I decoder with optional RV32M: a DEPTH-entry instruction FIFO
// feeding a registered decode stage that hands instructions to execute.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int EN_M  = 0,
    parameter int PC_W  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic [PC_W-1:0]        in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_W-1:0]        out_pc,
    output logic [31:0]            out_imm,
    output logic [4:0]             out_rs1,
    output logic [4:0]             out_rs2,
    output logic [4:0]             out_rd,
    output logic                   out_reg_write,
    output logic                   out_alu_src,
    output logic [3:0]             out_alu_ctrl,
    output logic                   out_wb_src,
    output logic                   out_alu_r1,
    output logic                   out_is_jal,
    output logic                   out_is_jalr,
    output logic                   out_is_b,
    output logic [2:0]             out_b_type,
    output logic [2:0]             out_is_load,
    output logic [2:0]             out_is_store,
    output logic                   out_is_md,
    output logic [2:0]             out_md_op,
    output logic                   out_illegal,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_write;
        logic        alu_src;
        logic [3:0]  alu_ctrl;
        logic        wb_src;
        logic        alu_r1;
        logic        is_jal;
        logic        is_jalr;
        logic        is_b;
        logic [2:0]  b_type;
        logic [2:0]  is_load;
        logic [2:0]  is_store;
        logic        is_md;
        logic [2:0]  md_op;
        logic        illegal;
    } dec_t;

    // Register fields pass through; every flag idle, load/store "none" = 111.
    function automatic dec_t blank(input logic [31:0] ins);
        dec_t d;
        d          = '0;
        d.rs1      = ins[19:15];
        d.rs2      = ins[24:20];
        d.rd       = ins[11:7];
        d.is_load  = 3'b111;
        d.is_store = 3'b111;
        return d;
    endfunction

    function automatic logic [3:0] alu_of_f3(input logic [2:0] f);
        logic [3:0] a;
        case (f)
            3'b000:  a = 4'b0000;
            3'b001:  a = 4'b1000;
            3'b010:  a = 4'b0110;
            3'b011:  a = 4'b0111;
            3'b100:  a = 4'b0101;
            3'b101:  a = 4'b1001;
            3'b110:  a = 4'b0100;
            default: a = 4'b0011;
        endcase
        return a;
    endfunction

    logic [31:0]     instr_mem [DEPTH];
    logic [PC_W-1:0] pc_mem    [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     cnt;
    logic            push, pop, bad;
    logic [31:0]     head, imm_i, imm_s, imm_b, imm_u, imm_j, shamt;
    logic [2:0]      f3;
    logic [6:0]      f7;
    dec_t            dec, dec_q;

    // A transfer happens on an edge where valid && ready; in_ready looks only at
    // the occupancy, and the output register is released by out_ready.
    assign in_ready = (cnt != FULL);
    assign push     = in_valid && in_ready;
    assign pop      = (cnt != '0) && (!out_valid || out_ready);
    assign count    = cnt;

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= in_instr;
            pc_mem[wr_ptr]    <= in_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      cnt <= cnt + (AW+1)'(1);
            else if (pop && !push) cnt <= cnt - (AW+1)'(1);
        end
    end

    assign head  = instr_mem[rd_ptr];
    assign f3    = head[14:12];
    assign f7    = head[31:25];
    assign imm_i = {{20{head[31]}}, head[31:20]};
    assign imm_s = {{20{head[31]}}, head[31:25], head[11:7]};
    assign imm_b = {{19{head[31]}}, head[31], head[7], head[30:25], head[11:8], 1'b0};
    assign imm_u = {head[31:12], 12'd0};
    assign imm_j = {{11{head[31]}}, head[31], head[19:12], head[20], head[30:21], 1'b0};
    assign shamt = {27'd0, head[24:20]};

    always_comb begin
        dec = blank(head);
        bad = 1'b0;
        case (head[6:0])
            7'b0110111: begin dec.reg_write = 1'b1; dec.wb_src = 1'b1; dec.imm = imm_u; end
            7'b0010111: begin
                dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_r1 = 1'b1; dec.imm = imm_u;
            end
            7'b1101111: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.is_jal = 1'b1; dec.imm = imm_j; end
            7'b1100111: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.is_jalr = 1'b1; dec.imm = imm_i; end
            7'b0000011: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.is_load = f3; dec.imm = imm_i; end
            7'b0100011: begin dec.alu_src = 1'b1; dec.is_store = f3; dec.imm = imm_s; end
            7'b1100011: begin
                dec.is_b = 1'b1;
                dec.imm  = imm_b;
                case (f3)
                    3'b000:  begin dec.b_type = 3'b001; dec.alu_ctrl = 4'b1011; end
                    3'b001:  begin dec.b_type = 3'b010; dec.alu_ctrl = 4'b1011; end
                    3'b100:  begin dec.b_type = 3'b011; dec.alu_ctrl = 4'b0110; end
                    3'b101:  begin dec.b_type = 3'b100; dec.alu_ctrl = 4'b0110; end
                    3'b110:  begin dec.b_type = 3'b101; dec.alu_ctrl = 4'b0111; end
                    3'b111:  begin dec.b_type = 3'b110; dec.alu_ctrl = 4'b0111; end
                    default: bad = 1'b1;
                endcase
            end
            7'b0010011: begin
                dec.reg_write = 1'b1;
                dec.alu_src   = 1'b1;
                dec.imm       = imm_i;
                dec.alu_ctrl  = alu_of_f3(f3);
                if (f3 == 3'b001) begin
                    dec.imm = shamt;
                    bad     = (f7 != 7'h00);
                end else if (f3 == 3'b101) begin
                    dec.imm = shamt;
                    if (f7 == 7'h20)      dec.alu_ctrl = 4'b1010;
                    else if (f7 != 7'h00) bad = 1'b1;
                end
            end
            7'b0110011: begin
                dec.reg_write = 1'b1;
                if (f7 == 7'h01) begin
                    if (EN_M != 0) begin dec.is_md = 1'b1; dec.md_op = f3; end
                    else bad = 1'b1;
                end else if (f7 == 7'h00) dec.alu_ctrl = alu_of_f3(f3);
                else if (f7 == 7'h20 && f3 == 3'b000) dec.alu_ctrl = 4'b0001;
                else if (f7 == 7'h20 && f3 == 3'b101) dec.alu_ctrl = 4'b1010;
                else bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase
        // Illegal entries still travel to execute so it can raise the trap.
        if (bad) begin
            dec         = blank(head);
            dec.illegal = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_pc    <= '0;
            dec_q     <= blank(32'd0);
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (pop) begin
            out_valid <= 1'b1;
            out_pc    <= pc_mem[rd_ptr];
            dec_q     <= dec;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_imm       = dec_q.imm;
    assign out_rs1       = dec_q.rs1;
    assign out_rs2       = dec_q.rs2;
    assign out_rd        = dec_q.rd;
    assign out_reg_write = dec_q.reg_write;
    assign out_alu_src   = dec_q.alu_src;
    assign out_alu_ctrl  = dec_q.alu_ctrl;
    assign out_wb_src    = dec_q.wb_src;
    assign out_alu_r1    = dec_q.alu_r1;
    assign out_is_jal    = dec_q.is_jal;
    assign out_is_jalr   = dec_q.is_jalr;
    assign out_is_b      = dec_q.is_b;
    assign out_b_type    = dec_q.b_type;
    assign out_is_load   = dec_q.is_load;
    assign out_is_store  = dec_q.is_store;
    assign out_is_md     = dec_q.is_md;
    assign out_md_op     = dec_q.md_op;
    assign out_illegal   = dec_q.illegal;
endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: two instances (EN_M=0 and EN_M=1) share all inputs and
// are checked every cycle against a transaction-level queue model.
module tb_decode_queue;
    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        reg_write;
        logic        alu_src;
        logic [3:0]  alu_ctrl;
        logic        wb_src;
        logic        alu_r1;
        logic        is_jal;
        logic        is_jalr;
        logic        is_b;
        logic [2:0]  b_type;
        logic [2:0]  is_load;
        logic [2:0]  is_store;
        logic        is_md;
        logic [2:0]  md_op;
        logic        illegal;
    } dec_t;

    // ---------------- clock / reset / inputs ----------------
    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [31:0]     in_instr = '0;
    logic [PC_W-1:0] in_pc = '0;

    always #5 clk = ~clk;

    logic            o_in_ready [2], o_out_valid [2], o_reg_write [2], o_alu_src [2];
    logic            o_wb_src [2], o_alu_r1 [2], o_is_jal [2], o_is_jalr [2];
    logic            o_is_b [2], o_is_md [2], o_illegal [2];
    logic [PC_W-1:0] o_out_pc [2];
    logic [31:0]     o_imm [2];
    logic [4:0]      o_rs1 [2], o_rs2 [2], o_rd [2];
    logic [3:0]      o_alu_ctrl [2];
    logic [2:0]      o_b_type [2], o_is_load [2], o_is_store [2], o_md_op [2];
    logic [CW-1:0]   o_count [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        decode_queue #(.DEPTH(DEPTH), .EN_M(g), .PC_W(PC_W)) dut (
            .clk(clk), .rst_n(rst_n), .flush(flush),
            .in_valid(in_valid), .in_ready(o_in_ready[g]),
            .in_instr(in_instr), .in_pc(in_pc),
            .out_valid(o_out_valid[g]), .out_ready(out_ready),
            .out_pc(o_out_pc[g]), .out_imm(o_imm[g]),
            .out_rs1(o_rs1[g]), .out_rs2(o_rs2[g]), .out_rd(o_rd[g]),
            .out_reg_write(o_reg_write[g]), .out_alu_src(o_alu_src[g]),
            .out_alu_ctrl(o_alu_ctrl[g]), .out_wb_src(o_wb_src[g]),
            .out_alu_r1(o_alu_r1[g]), .out_is_jal(o_is_jal[g]),
            .out_is_jalr(o_is_jalr[g]), .out_is_b(o_is_b[g]),
            .out_b_type(o_b_type[g]), .out_is_load(o_is_load[g]),
            .out_is_store(o_is_store[g]), .out_is_md(o_is_md[g]),
            .out_md_op(o_md_op[g]), .out_illegal(o_illegal[g]),
            .count(o_count[g])
        );
    end

    // ---------------- scoreboard bookkeeping ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic dec_t exp_dec(input logic [31:0] i, input int en_m);
        dec_t d;
        logic [3:0] alu_tab [8];
        logic [2:0] f3;
        logic [6:0] f7;
        bit ok;
        alu_tab = '{4'b0000, 4'b1000, 4'b0110, 4'b0111, 4'b0101, 4'b1001, 4'b0100, 4'b0011};
        f3 = i[14:12];
        f7 = i[31:25];
        d = '0;
        d.rs1 = i[19:15]; d.rs2 = i[24:20]; d.rd = i[11:7];
        d.is_load = 3'b111; d.is_store = 3'b111;
        ok = 1;
        case (i[6:0])
            7'b0110111: begin d.reg_write = 1; d.wb_src = 1; d.imm = {i[31:12], 12'd0}; end
            7'b0010111: begin d.reg_write = 1; d.alu_src = 1; d.alu_r1 = 1; d.imm = {i[31:12], 12'd0}; end
            7'b1101111: begin
                d.reg_write = 1; d.alu_src = 1; d.is_jal = 1;
                d.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            end
            7'b1100111: begin d.reg_write = 1; d.alu_src = 1; d.is_jalr = 1; d.imm = {{20{i[31]}}, i[31:20]}; end
            7'b0000011: begin d.reg_write = 1; d.alu_src = 1; d.is_load = f3; d.imm = {{20{i[31]}}, i[31:20]}; end
            7'b0100011: begin d.alu_src = 1; d.is_store = f3; d.imm = {{20{i[31]}}, i[31:25], i[11:7]}; end
            7'b1100011: begin
                d.is_b = 1;
                d.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
                ok = (f3 != 3'b010) && (f3 != 3'b011);
                d.b_type = (f3 < 3'd4) ? f3 + 3'd1 : f3 - 3'd1;
                d.alu_ctrl = (f3[2:1] == 2'b00) ? 4'b1011 : (f3[1] ? 4'b0111 : 4'b0110);
            end
            7'b0010011: begin
                d.reg_write = 1; d.alu_src = 1; d.imm = {{20{i[31]}}, i[31:20]};
                d.alu_ctrl = alu_tab[f3];
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    d.imm = {27'd0, i[24:20]};
                    if (f3 == 3'b101 && f7 == 7'b0100000) d.alu_ctrl = 4'b1010;
                    else ok = (f7 == 7'd0);
                end
            end
            7'b0110011: begin
                d.reg_write = 1;
                if (f7 == 7'b0000001) begin ok = (en_m != 0); d.is_md = 1; d.md_op = f3; end
                else if (f7 == 7'd0) d.alu_ctrl = alu_tab[f3];
                else if (f7 == 7'b0100000 && f3 == 3'b000) d.alu_ctrl = 4'b0001;
                else if (f7 == 7'b0100000 && f3 == 3'b101) d.alu_ctrl = 4'b1010;
                else ok = 0;
            end
            default: ok = 0;
        endcase
        if (!ok) begin
            d = '0;
            d.rs1 = i[19:15]; d.rs2 = i[24:20]; d.rd = i[11:7];
            d.is_load = 3'b111; d.is_store = 3'b111;
            d.illegal = 1;
        end
        return d;
    endfunction

    logic [63:0]     exp_q [$];      // {pc, instr} waiting in the FIFO
    bit              m_valid = 0;
    logic [31:0]     m_instr = '0;
    logic [PC_W-1:0] m_pc = '0;

    initial begin
        bit push, pop;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_q.delete();
                m_valid = 0;
            end else if (flush) begin
                exp_q.delete();
                m_valid = 0;
            end else begin
                push = in_valid && (exp_q.size() < DEPTH);
                pop  = (exp_q.size() != 0) && (!m_valid || out_ready);
                if (pop) begin
                    {m_pc, m_instr} = exp_q.pop_front();
                    m_valid = 1;
                end else if (out_ready) begin
                    m_valid = 0;
                end
                if (push) exp_q.push_back({in_pc, in_instr});
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        dec_t got;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int g = 0; g < 2; g++) begin
                    chk($sformatf("dut%0d.in_ready", g), o_in_ready[g], exp_q.size() < DEPTH);
                    chk($sformatf("dut%0d.count", g), o_count[g], exp_q.size());
                    chk($sformatf("dut%0d.out_valid", g), o_out_valid[g], m_valid);
                    if (m_valid) begin
                        got = {o_imm[g], o_rs1[g], o_rs2[g], o_rd[g], o_reg_write[g], o_alu_src[g],
                               o_alu_ctrl[g], o_wb_src[g], o_alu_r1[g], o_is_jal[g], o_is_jalr[g],
                               o_is_b[g], o_b_type[g], o_is_load[g], o_is_store[g], o_is_md[g],
                               o_md_op[g], o_illegal[g]};
                        chk($sformatf("dut%0d.out_pc", g), o_out_pc[g], m_pc);
                        chk($sformatf("dut%0d.decode(%h)", g, m_instr), got, exp_dec(m_instr, g));
                    end
                end
            end
        end
    end

    // Delivered PCs, used to check ordering across pointer wrap.
    logic [PC_W-1:0] dlv_q [$];
    bit              dlv_en = 0;
    initial forever begin
        @(posedge clk);
        if (rst_n && dlv_en && o_out_valid[0] && out_ready) dlv_q.push_back(o_out_pc[0]);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] ins, input logic [PC_W-1:0] pc);
        int n = 0;
        in_valid = 1; in_instr = ins; in_pc = pc;
        while (!o_in_ready[0] && n < 20) begin tick(); n++; end
        chk("push.in_ready", o_in_ready[0], 1);
        tick();
        in_valid = 0;
    endtask

    task automatic wait_out(input string what);
        int n = 0;
        while (!o_out_valid[0] && n < 10) begin tick(); n++; end
        chk({what, ".out_valid"}, o_out_valid[0], 1);
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1;
        while ((o_count[0] != 0 || o_out_valid[0]) && n < 40) begin tick(); n++; end
        chk("drain.idle", (o_count[0] == 0) && !o_out_valid[0], 1);
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] prog [8];
    logic [31:0] mix [12];

    initial begin
        int idx, guard;
        bit will;
        prog = '{32'h123452B7, 32'h00001317, 32'h402083B3, 32'h4030D413,
                 32'h0040A483, 32'h0020A423, 32'h010000EF, 32'h0262D233};
        mix  = '{32'h2030D413, 32'h0020A463, 32'h00008067, 32'h00209093,
                 32'h40209093, 32'h007362B3, 32'h402090B3, 32'hFE209EE3,
                 32'h00208023, 32'h0040C503, 32'h0220E1B3, 32'h022081B3};

        // Reset values while rst_n is held low.
        repeat (2) @(posedge clk);
        #1;
        chk("rst.count", o_count[0], 0);
        chk("rst.in_ready", o_in_ready[0], 1);
        chk("rst.out_valid", o_out_valid[0], 0);
        chk("rst.is_load", o_is_load[0], 3'b111);
        chk("rst.is_store", o_is_store[0], 3'b111);
        chk("rst.imm", o_imm[0], 0);
        rst_n = 1;
        tick();

        // ADDI x1,x0,-5: visible two edges after the push handshake.
        out_ready = 1;
        in_valid = 1; in_instr = 32'hFFB00093; in_pc = 32'h100;
        tick();
        in_valid = 0;
        chk("addi.valid_edge1", o_out_valid[0], 0);
        chk("addi.count_edge1", o_count[0], 1);
        tick();
        chk("addi.valid_edge2", o_out_valid[0], 1);
        chk("addi.imm", o_imm[0], 32'hFFFFFFFB);
        chk("addi.rd", o_rd[0], 1);
        chk("addi.alu_ctrl", o_alu_ctrl[0], 4'b0000);
        chk("addi.alu_src", o_alu_src[0], 1);
        chk("addi.reg_write", o_reg_write[0], 1);
        chk("addi.illegal", o_illegal[0], 0);
        chk("addi.pc", o_out_pc[0], 32'h100);
        tick();

        // Back-pressure: fill with out_ready low, then release.
        out_ready = 0; dlv_en = 1; idx = 0; guard = 0;
        while (o_in_ready[0] && idx < 8 && guard < 20) begin
            in_valid = 1; in_instr = prog[idx]; in_pc = 32'h200 + 4 * idx;
            tick(); idx++; guard++;
        end
        in_valid = 0;
        chk("bp.accepts", idx, 5);
        chk("bp.count", o_count[0], 4);
        chk("bp.in_ready", o_in_ready[0], 0);
        repeat (3) tick();
        chk("bp.hold_pc", o_out_pc[0], 32'h200);
        chk("bp.hold_imm", o_imm[0], 32'h12345000);
        out_ready = 1;
        while (idx < 8 && guard < 40) begin
            in_valid = 1; in_instr = prog[idx]; in_pc = 32'h200 + 4 * idx;
            will = o_in_ready[0];
            tick(); guard++;
            if (will) idx++;
        end
        in_valid = 0;
        drain();
        dlv_en = 0;
        chk("bp.delivered", dlv_q.size(), 8);
        for (int i = 0; i < 8 && i < dlv_q.size(); i++)
            chk($sformatf("bp.order%0d", i), dlv_q[i], 32'h200 + 4 * i);

        // MUL x3,x1,x2 in both builds.
        push_one(32'h022081B3, 32'h300);
        wait_out("mul");
        chk("mul.m0.illegal", o_illegal[0], 1);
        chk("mul.m0.reg_write", o_reg_write[0], 0);
        chk("mul.m1.is_md", o_is_md[1], 1);
        chk("mul.m1.md_op", o_md_op[1], 3'b000);
        chk("mul.m1.reg_write", o_reg_write[1], 1);
        chk("mul.m1.illegal", o_illegal[1], 0);
        tick();

        // BGEU x1,x2,+8.
        push_one(32'h0020F463, 32'h304);
        wait_out("bgeu");
        chk("bgeu.is_b", o_is_b[0], 1);
        chk("bgeu.b_type", o_b_type[0], 3'b110);
        chk("bgeu.alu_ctrl", o_alu_ctrl[0], 4'b0111);
        chk("bgeu.imm", o_imm[0], 32'd8);
        tick();

        // Unknown opcode 0x7F.
        push_one(32'h0000007F, 32'h308);
        wait_out("opc7f");
        chk("opc7f.illegal", o_illegal[0], 1);
        chk("opc7f.is_load", o_is_load[0], 3'b111);
        chk("opc7f.is_store", o_is_store[0], 3'b111);
        chk("opc7f.reg_write", o_reg_write[0], 0);
        tick();

        // Mixed legal/illegal encodings with a stuttering consumer.
        for (int i = 0; i < 12; i++) begin
            out_ready = (i % 3 != 2);
            push_one(mix[i], 32'h400 + 4 * i);
        end
        drain();

        // Flush with 3 queued plus one registered, concurrent push dropped.
        out_ready = 0;
        for (int i = 0; i < 4; i++) push_one(32'h00100093 + (i << 7), 32'h500 + 4 * i);
        chk("flush.pre_count", o_count[0], 3);
        chk("flush.pre_valid", o_out_valid[0], 1);
        flush = 1; in_valid = 1; in_instr = 32'h00500293; in_pc = 32'h5F0;
        tick();
        flush = 0; in_valid = 0;
        chk("flush.count", o_count[0], 0);
        chk("flush.out_valid", o_out_valid[0], 0);
        chk("flush.in_ready", o_in_ready[0], 1);
        out_ready = 1;
        repeat (2) tick();
        chk("flush.dropped_valid", o_out_valid[0], 0);
        chk("flush.dropped_count", o_count[0], 0);

        // Asynchronous reset between edges, mid-stream.
        in_valid = 1; in_instr = 32'h123452B7; in_pc = 32'h600;
        repeat (3) tick();
        chk("areset.pre_valid", o_out_valid[0], 1);
        #2;
        rst_n = 0; in_valid = 0;
        #1;
        chk("areset.count", o_count[0], 0);
        chk("areset.out_valid", o_out_valid[0], 0);
        chk("areset.out_valid_m", o_out_valid[1], 0);
        chk("areset.in_ready", o_in_ready[0], 1);
        chk("areset.imm", o_imm[0], 0);
        chk("areset.is_load", o_is_load[0], 3'b111);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        tick();
        push_one(32'hFFB00093, 32'h700);
        wait_out("recover");
        chk("recover.imm", o_imm[0], 32'hFFFFFFFB);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
